ifu_fetch: RTL and testbench

Instruction fetch unit for the MIPS-lite core; it sits directly upstream of the control decoder and datapath. It holds the PC and fetches instruction words from a variable-latency instruction memory over a req/ready handshake. It presents each word, with a valid flag, to the decoder. When the datapath signals completion, it computes the next PC from the decoder's npc_jmp select and the ALU zero flag.

---
 rtl/ifu_fetch.sv | 98 +++++++++
 tb/tb_ifu_fetch.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_fetch.sv
// ifu_fetch: holds the PC, fetches instruction words from a variable-latency
// instruction memory over a req/ready handshake, presents each word to the
// decoder and steps the PC (sequential, beq or j) when the datapath advances.
module ifu_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_3000,
   parameter int          CNT_W    = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       npc_jmp,
   input  logic             zero,
   input  logic             advance,
   output logic             imem_req,
   output logic [31:0]      imem_addr,
   input  logic [31:0]      imem_rdata,
   input  logic             imem_ready,
   output logic [31:0]      instruction,
   output logic             instr_valid,
   output logic [31:0]      pc,
   output logic [31:0]      pc_plus4,
   output logic [CNT_W-1:0] retired
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      ISSUE = 2'd2
   } state_t;

   state_t      state;
   logic [31:0] next_pc;
   logic [31:0] br_offset;

   // The fetch address is always the PC of the instruction being fetched.
   assign imem_addr = pc;
   assign pc_plus4  = pc + 32'd4;

   // beq offset: sign-extended word offset, scaled to bytes.
   assign br_offset = {{14{instruction[15]}}, instruction[15:0], 2'b00};

   // Next-PC select from the decoder; the reserved encoding behaves as sequential.
   always_comb begin
      // NOTE: next_pc gets a default before the case so every path assigns it
      // and no latch is inferred.
      next_pc = pc_plus4;
      case (npc_jmp)
         2'b01:   if (zero) next_pc = pc_plus4 + br_offset;
         2'b10:   next_pc = {pc_plus4[31:28], instruction[25:0], 2'b00};
         default: next_pc = pc_plus4;
      endcase
   end

   // Fetch sequencer: IDLE leaves reset, FETCH waits for memory, ISSUE waits for advance.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         pc          <= RESET_PC;
         instruction <= 32'h0;
         instr_valid <= 1'b0;
         imem_req    <= 1'b0;
         retired     <= '0;
      end else begin
         // NOTE: all state here uses non-blocking assignments so every register
         // samples the pre-edge values, independent of statement order.
         case (state)
            IDLE: begin
               imem_req <= 1'b1;
               state    <= FETCH;
            end
            FETCH: begin
               // advance is ignored here; only the memory response moves us on.
               if (imem_ready) begin
                  instruction <= imem_rdata;
                  instr_valid <= 1'b1;
                  imem_req    <= 1'b0;
                  state       <= ISSUE;
               end
            end
            ISSUE: begin
               // imem_ready is ignored here; the word is held until advance.
               if (advance) begin
                  pc          <= next_pc;
                  instr_valid <= 1'b0;
                  retired     <= retired + CNT_W'(1);
                  imem_req    <= 1'b1;
                  state       <= FETCH;
               end
            end
            default: begin
               imem_req    <= 1'b0;
               instr_valid <= 1'b0;
               state       <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: a scoreboard checks every fetch request and every
// presented instruction of the main instance against hand-computed values;
// a second instance at RESET_PC=FFFF_FFFC with a 2-bit counter covers the
// address and retired-count wrap.
module tb_ifu_fetch;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // Main instance signals.
   logic        rst, zero, advance, imem_req, imem_ready, instr_valid;
   logic [1:0]  npc_jmp;
   logic [31:0] imem_addr, imem_rdata, instruction, pc, pc_plus4, retired;

   // Wrap instance signals.
   logic        rst_w, zero_w, adv_w, req_w, ready_w, valid_w;
   logic [1:0]  npc_w, ret_w;
   logic [31:0] addr_w, rdata_w, instr_w, pc_w, pc4_w;

   ifu_fetch dut (
      .clk(clk), .rst(rst), .npc_jmp(npc_jmp), .zero(zero), .advance(advance),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
      .imem_ready(imem_ready), .instruction(instruction), .instr_valid(instr_valid),
      .pc(pc), .pc_plus4(pc_plus4), .retired(retired)
   );

   ifu_fetch #(.RESET_PC(32'hFFFF_FFFC), .CNT_W(2)) dut_w (
      .clk(clk), .rst(rst_w), .npc_jmp(npc_w), .zero(zero_w), .advance(adv_w),
      .imem_req(req_w), .imem_addr(addr_w), .imem_rdata(rdata_w),
      .imem_ready(ready_w), .instruction(instr_w), .instr_valid(valid_w),
      .pc(pc_w), .pc_plus4(pc4_w), .retired(ret_w)
   );

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Instruction memory contents for the main instance.
   logic [31:0] mem [logic [31:0]];

   function automatic logic [31:0] rd(input logic [31:0] a);
      return mem.exists(a) ? mem[a] : 32'h0;
   endfunction

   // Memory model: ready after mem_wait idle cycles of a held request.
   int mem_wait = 0;
   initial begin
      int cnt = 0;
      imem_ready = 1'b0;
      imem_rdata = 32'h0;
      forever begin
         @(posedge clk);
         #1;
         if (rst || !imem_req) begin
            imem_ready = 1'b0;
            imem_rdata = $urandom;
            cnt        = 0;
         end else if (cnt >= mem_wait) begin
            imem_ready = 1'b1;
            imem_rdata = rd(imem_addr);
         end else begin
            imem_ready = 1'b0;
            imem_rdata = $urandom;
            cnt++;
         end
      end
   end

   // Scoreboard queues: expected request addresses and expected presented words.
   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
      logic [31:0] ret;
   } issue_t;

   logic [31:0] req_q [$];
   issue_t      iss_q [$];

   // Monitor: compares on every request rise and every instr_valid rise.
   initial begin
      logic        prev_req    = 1'b0;
      logic        prev_valid  = 1'b0;
      logic        prev_accept = 1'b0;
      logic [31:0] exp_a;
      issue_t      e;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_req    = 1'b0;
            prev_valid  = 1'b0;
            prev_accept = 1'b0;
         end else begin
            if (imem_req && !prev_req) begin
               if (req_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_req: got addr %h expected no request", imem_addr);
               end else begin
                  exp_a = req_q.pop_front();
                  check("req_addr", imem_addr, exp_a);
                  check("req_pc", pc, exp_a);
               end
            end
            if (instr_valid && !prev_valid) begin
               check("valid_latency", 32'(prev_accept), 32'd1);
               if (iss_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_valid: got pc %h expected no instruction", pc);
               end else begin
                  e = iss_q.pop_front();
                  check("issue_instr", instruction, e.instr);
                  check("issue_pc", pc, e.pc);
                  check("issue_pc_plus4", pc_plus4, e.pc + 32'd4);
                  check("issue_retired", retired, e.ret);
               end
            end
            prev_req    = imem_req;
            prev_valid  = instr_valid;
            prev_accept = imem_req && imem_ready;
         end
      end
   end

   task automatic wait_valid();
      bit ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (instr_valid) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL valid_timeout: got no instr_valid expected one within 50 cycles");
      end
   endtask

   // Wait for the presented word, then advance with the given select and
   // queue the hand-computed next fetch.
   task automatic step(input logic [1:0] sel, input logic z, input logic [31:0] nxt,
                       input logic [31:0] ret_after, input int w);
      issue_t e;
      wait_valid();
      e.pc    = nxt;
      e.instr = rd(nxt);
      e.ret   = ret_after;
      req_q.push_back(nxt);
      iss_q.push_back(e);
      mem_wait = w;
      npc_jmp  = sel;
      zero     = z;
      advance  = 1'b1;
      @(negedge clk);
      advance = 1'b0;
      npc_jmp = 2'b00;
      zero    = 1'b0;
   endtask

   // Directed vectors: select, zero flag, expected next fetch address.
   logic [1:0]  v_sel [11] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b11, 2'b10,
                               2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
   logic        v_z   [11] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0,
                               1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
   logic [31:0] v_nxt [11] = '{32'h3004, 32'h3008, 32'h3008, 32'h300C, 32'h3010, 32'h300C,
                               32'h3010, 32'h3014, 32'h3018, 32'h301C, 32'h3020};

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish before 200000");
      $fatal(1, "watchdog");
   end

   initial begin
      issue_t e;
      logic [31:0] exp_pc;
      logic [1:0]  exp_ret;

      mem[32'h3000] = 32'h3C01_0001;
      mem[32'h3004] = 32'h2402_0005;
      mem[32'h3008] = 32'h1000_FFFF;
      mem[32'h300C] = 32'h0043_0820;
      mem[32'h3010] = 32'h0800_0C03;
      mem[32'h3014] = 32'h3C03_ABCD;
      mem[32'h3018] = 32'h0000_0000;
      mem[32'h301C] = 32'hAC01_0004;
      mem[32'h3020] = 32'h8C02_0000;

      rst = 1'b1; npc_jmp = 2'b00; zero = 1'b0; advance = 1'b0;
      rst_w = 1'b1; npc_w = 2'b00; zero_w = 1'b0; adv_w = 1'b0;
      ready_w = 1'b0; rdata_w = 32'h0;

      // Reset state of the main instance.
      @(negedge clk);
      check("rst_req", 32'(imem_req), 32'd0);
      check("rst_valid", 32'(instr_valid), 32'd0);
      check("rst_pc", pc, 32'h3000);
      check("rst_instr", instruction, 32'h0);
      check("rst_retired", retired, 32'd0);

      e.pc = 32'h3000; e.instr = rd(32'h3000); e.ret = 32'd0;
      req_q.push_back(32'h3000);
      iss_q.push_back(e);
      rst = 1'b0;
      @(negedge clk);
      check("req_one_cycle_after_reset", 32'(imem_req), 32'd1);

      for (int i = 0; i < 11; i++)
         step(v_sel[i], v_z[i], v_nxt[i], 32'(i + 1), (i == 10) ? 8 : 0);

      // Stalled fetch at 0x3020: request held, address stable, advance ignored.
      for (int i = 0; i < 3; i++) begin
         advance = 1'b1;
         npc_jmp = 2'b10;
         @(negedge clk);
         check("stall_req", 32'(imem_req), 32'd1);
         check("stall_addr", imem_addr, 32'h3020);
         check("stall_valid", 32'(instr_valid), 32'd0);
         check("stall_retired", retired, 32'd11);
      end
      advance = 1'b0;
      npc_jmp = 2'b00;

      // Reset mid-FETCH takes effect immediately.
      rst = 1'b1;
      #1;
      check("midrst_req", 32'(imem_req), 32'd0);
      check("midrst_pc", pc, 32'h3000);
      check("midrst_addr", imem_addr, 32'h3000);
      check("midrst_valid", 32'(instr_valid), 32'd0);
      check("midrst_instr", instruction, 32'h0);
      check("midrst_retired", retired, 32'd0);
      check("req_q_drained", 32'(req_q.size()), 32'd0);
      iss_q.delete();
      mem_wait = 0;
      e.pc = 32'h3000; e.instr = rd(32'h3000); e.ret = 32'd0;
      req_q.push_back(32'h3000);
      iss_q.push_back(e);
      @(negedge clk);
      rst = 1'b0;
      step(2'b00, 1'b0, 32'h3004, 32'd1, 0);
      wait_valid();

      // Wrap instance: top-of-memory reset PC and 2-bit retired counter.
      check("w_rst_pc", pc_w, 32'hFFFF_FFFC);
      check("w_rst_req", 32'(req_w), 32'd0);
      rst_w = 1'b0;
      @(negedge clk);
      check("w_req", 32'(req_w), 32'd1);
      check("w_addr", addr_w, 32'hFFFF_FFFC);
      exp_pc  = 32'hFFFF_FFFC;
      exp_ret = 2'd0;
      for (int i = 0; i < 5; i++) begin
         ready_w = 1'b1;
         rdata_w = 32'h0;
         @(negedge clk);
         ready_w = 1'b0;
         check("w_valid", 32'(valid_w), 32'd1);
         check("w_pc", pc_w, exp_pc);
         check("w_pc_plus4", pc4_w, exp_pc + 32'd4);
         adv_w = 1'b1;
         @(negedge clk);
         adv_w   = 1'b0;
         exp_pc  = exp_pc + 32'd4;
         exp_ret = exp_ret + 2'd1;
         check("w_next_req", 32'(req_w), 32'd1);
         check("w_next_addr", addr_w, exp_pc);
         check("w_retired", 32'(ret_w), 32'(exp_ret));
      end

      check("req_q_empty", 32'(req_q.size()), 32'd0);
      check("iss_q_empty", 32'(iss_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
